// File: rtl/ifft_pkg.sv
// Shared constants for the IFFT twiddle-multiply datapath.
//   DEF_*      : default widths used by the stage parameters
//   TW_ONE     : Q8 encoding of +1.0
//   SAT_MAX/MIN: saturation bounds for a DEF_DATA_W-bit result
package ifft_pkg;

  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_TW_W    = 16;
  localparam int unsigned DEF_TW_FRAC = 8;
  localparam int unsigned DEF_ADDR_W  = 5;

  localparam logic [DEF_TW_W-1:0] TW_ONE = 16'h0100;

  localparam logic signed [DEF_DATA_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [DEF_DATA_W-1:0] SAT_MIN = 16'sh8000;

endpackage

// File: rtl/ifft_round_sat.sv
// Round-half-up and saturate a wide signed sum down to DATA_W bits.
//   sum_in  : IN_W-bit two's-complement sum
//   sat_out : (sum_in + 2^(FRAC-1)) >>> FRAC, clamped to the DATA_W range
// Purely combinational.
module ifft_round_sat
  import ifft_pkg::*;
#(
  parameter int unsigned IN_W   = 2 * DEF_DATA_W + 1,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned FRAC   = DEF_TW_FRAC
) (
  input  logic signed [IN_W-1:0]   sum_in,
  output logic signed [DATA_W-1:0] sat_out
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam logic [IN_W:0] RND_ADD =
    {{(IN_W + 1 - FRAC){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};
  localparam logic signed [IN_W:0] MAX_V =
    {{(IN_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V =
    {{(IN_W + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};

  logic signed [IN_W:0] ext;
  logic signed [IN_W:0] rnd;
  logic signed [IN_W:0] shr;

  always_comb begin
    ext = {sum_in[IN_W-1], sum_in};
    rnd = ext + RND_ADD;
    shr = rnd >>> FRAC;
    if (shr > MAX_V) begin
      sat_out = MAX_V[DATA_W-1:0];
    end else if (shr < MIN_V) begin
      sat_out = MIN_V[DATA_W-1:0];
    end else begin
      sat_out = shr[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/ifft_twiddle_mult.sv
// IFFT twiddle-multiply stage: complex sample x Q-format twiddle from a pair
// of synchronous (1-cycle) ROMs, rounded and saturated, 3-stage pipeline.
//   in_valid/in_ready/in_re/in_im/in_addr : upstream beat + twiddle index
//   rom_addr, rom_re_data, rom_im_data    : shared twiddle ROM port
//   out_valid/out_ready/out_re/out_im     : product to the butterfly
// Every stage advances on en = !out_valid || out_ready.
module ifft_twiddle_mult
  import ifft_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TW_W    = DEF_TW_W,
  parameter int unsigned TW_FRAC = DEF_TW_FRAC,
  parameter int unsigned ADDR_W  = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  input  logic [ADDR_W-1:0] in_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [TW_W-1:0]   rom_re_data,
  input  logic [TW_W-1:0]   rom_im_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im
);

  localparam int unsigned PROD_W = DATA_W + TW_W;
  localparam int unsigned SUM_W  = PROD_W + 1;

  logic en;
  logic accept;

  logic [ADDR_W-1:0]        addr_hold_q, addr_hold_d;
  logic                     v1_q, v1_d, v2_q, v2_d, out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic signed [TW_W-1:0]   tw_c, tw_d;
  logic signed [PROD_W-1:0] ac_q, ac_d, bd_q, bd_d, ad_q, ad_d, bc_q, bc_d;
  logic signed [SUM_W-1:0]  sum_re, sum_im;
  logic signed [DATA_W-1:0] rs_re, rs_im;
  logic [DATA_W-1:0]        out_re_q, out_re_d, out_im_q, out_im_d;

  assign tw_c = rom_re_data;
  assign tw_d = rom_im_data;

  assign sum_re = SUM_W'(ac_q) - SUM_W'(bd_q);
  assign sum_im = SUM_W'(ad_q) + SUM_W'(bc_q);

  ifft_round_sat #(.IN_W(SUM_W), .DATA_W(DATA_W), .FRAC(TW_FRAC)) u_rs_re (
    .sum_in  (sum_re),
    .sat_out (rs_re)
  );

  ifft_round_sat #(.IN_W(SUM_W), .DATA_W(DATA_W), .FRAC(TW_FRAC)) u_rs_im (
    .sum_in  (sum_im),
    .sat_out (rs_im)
  );

  always_comb begin
    en     = !out_valid_q || out_ready;
    accept = in_valid && en;
    // Re-presenting the held address during a stall keeps the ROM output
    // aligned with the frozen S1 sample.
    rom_addr = accept ? in_addr : addr_hold_q;

    addr_hold_d = addr_hold_q;
    a_d         = a_q;
    b_d         = b_q;
    v1_d        = v1_q;
    v2_d        = v2_q;
    out_valid_d = out_valid_q;
    ac_d        = ac_q;
    bd_d        = bd_q;
    ad_d        = ad_q;
    bc_d        = bc_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;

    if (accept) begin
      addr_hold_d = in_addr;
      a_d         = in_re;
      b_d         = in_im;
    end

    if (en) begin
      v1_d        = accept;
      v2_d        = v1_q;
      out_valid_d = v2_q;
      if (v1_q) begin
        ac_d = PROD_W'(a_q) * PROD_W'(tw_c);
        bd_d = PROD_W'(b_q) * PROD_W'(tw_d);
        ad_d = PROD_W'(a_q) * PROD_W'(tw_d);
        bc_d = PROD_W'(b_q) * PROD_W'(tw_c);
      end
      if (v2_q) begin
        out_re_d = rs_re;
        out_im_d = rs_im;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_hold_q <= '0;
      a_q         <= '0;
      b_q         <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      ac_q        <= '0;
      bd_q        <= '0;
      ad_q        <= '0;
      bc_q        <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      addr_hold_q <= addr_hold_d;
      a_q         <= a_d;
      b_q         <= b_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      out_valid_q <= out_valid_d;
      ac_q        <= ac_d;
      bd_q        <= bd_d;
      ad_q        <= ad_d;
      bc_q        <= bc_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;

endmodule

// File: tb/tb_ifft_twiddle_mult.sv
module tb_ifft_twiddle_mult;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_re, in_im;
  logic [4:0]  in_addr;
  logic [4:0]  rom_addr;
  logic [15:0] rom_re_data, rom_im_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_re, out_im;

  int checks = 0;
  int errors = 0;

  int          tw_re_tab[32];
  int          tw_im_tab[32];
  logic [31:0] exp_q[$];
  logic [4:0]  last_addr = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_out = '0;

  always #5 clk = ~clk;

  ifft_twiddle_mult #(.DATA_W(16), .TW_W(16), .TW_FRAC(8), .ADDR_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_re       (in_re),
    .in_im       (in_im),
    .in_addr     (in_addr),
    .rom_addr    (rom_addr),
    .rom_re_data (rom_re_data),
    .rom_im_data (rom_im_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_re      (out_re),
    .out_im      (out_im)
  );

  // Registered 1-cycle twiddle ROMs
  always @(posedge clk) begin
    rom_re_data <= 16'(tw_re_tab[rom_addr]);
    rom_im_data <= 16'(tw_im_tab[rom_addr]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] round_sat(input longint x);
    longint y;
    longint q;
    y = x + 128;
    if (y >= 0) q = y / 256;
    else        q = -((-y + 255) / 256);
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return 16'(q);
  endfunction

  function automatic logic [31:0] model(input int a, input int b, input int c, input int d);
    longint pr;
    longint pi;
    pr = longint'(a) * c - longint'(b) * d;
    pi = longint'(a) * d + longint'(b) * c;
    return {round_sat(pr), round_sat(pi)};
  endfunction

  // Scoreboard and stall monitors, sampled on the falling edge
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(int'($signed(in_re)), int'($signed(in_im)),
                              tw_re_tab[in_addr], tw_im_tab[in_addr]));
        last_addr = in_addr;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("out_data", {out_re, out_im}, e);
        end
      end
      if (prev_stall && out_valid)
        check("stall_hold", {out_re, out_im}, prev_out);
      if (out_valid && !out_ready) begin
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_rom_addr", 32'(rom_addr), 32'(last_addr));
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_re, out_im};
    end
  end

  // Present a beat and hold it until accepted; returns #1 after the accepting edge
  task automatic send(input int re, input int im, input logic [4:0] addr);
    int   n;
    logic acc;
    n        = 0;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_re    = 16'(re);
    in_im    = 16'(im);
    in_addr  = addr;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) check("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      tw_re_tab[i] = int'($urandom_range(0, 511)) - 256;
      tw_im_tab[i] = int'($urandom_range(0, 511)) - 256;
    end
    tw_re_tab[0] = 256; tw_im_tab[0] = 0;
    tw_re_tab[1] = 0;   tw_im_tab[1] = 256;
    tw_re_tab[2] = 128; tw_im_tab[2] = 0;
    tw_re_tab[3] = 181; tw_im_tab[3] = 181;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    in_addr   = 5'd9;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_out_data", {out_re, out_im}, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Identity: output valid after the third rising edge counting the accepting edge
    send(1000, -500, 5'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("ident_lat_e2", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("ident_lat_e3", 32'(out_valid), 32'd1);
    check("ident_value", {out_re, out_im}, {16'(1000), 16'(-500)});
    drain();

    // Rotate by j
    send(1000, -500, 5'd1);
    in_valid = 1'b0;
    drain();
    check("rotj_last", {out_re, out_im}, {16'(500), 16'(1000)});

    // Rounding and saturation, back to back
    send(1, 0, 5'd2);
    send(-1, 0, 5'd2);
    send(32767, 32767, 5'd3);
    in_valid = 1'b0;
    drain();
    check("sat_last", {out_re, out_im}, {16'(0), 16'(32767)});

    // Backpressure: 8 beats, out_ready low for 5 cycles mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(int'($urandom_range(0, 65535)) - 32768,
               int'($urandom_range(0, 65535)) - 32768, 5'(8 + i));
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight
    send(300, 400, 5'd5);
    send(-700, 20, 5'd6);
    send(12345, -2345, 5'd7);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_rom_addr", 32'(rom_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(1234, -77, 5'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("postrst_lat_e2", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("postrst_lat_e3", 32'(out_valid), 32'd1);
    check("postrst_value", {out_re, out_im}, {16'(1234), 16'(-77)});
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
